// File: rtl/float_mul_e4m3_if.sv
// Operand/result bundle for the E4M3 multiplier: the master drives operands and start,
// the slave returns busy, the packed product and its one-cycle valid pulse.
interface float_mul_e4m3_if;
  logic [7:0] a;
  logic [7:0] b;
  logic       start;
  logic       busy;
  logic [7:0] y;
  logic       is_output_valid;

  modport master (output a, b, start, input busy, y, is_output_valid);
  modport slave  (input a, b, start, output busy, y, is_output_valid);
endinterface

// File: rtl/float_mul_e4m3.sv
// Multi-cycle E4M3 multiplier: 4-step shift-add significand product, then normalise/pack.
// Define FLOAT_MUL_SATURATE_EN to clamp exponent overflow to max magnitude instead of wrapping.
module float_mul_e4m3 #(
  parameter int EXP_BIAS = 7
) (
  input  logic              clock,
  input  logic              reset,
  float_mul_e4m3_if.slave   bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] NORM = 2'd2;

  localparam logic signed [5:0] BIAS = 6'(EXP_BIAS);

  logic [1:0] state;
  logic [7:0] acc;
  logic [1:0] cnt;
  logic [7:0] y_r;
  logic       valid_r;

  logic [3:0] ma;
  logic [3:0] mb;
  logic [3:0] ea;
  logic [3:0] eb;
  logic       sign;
  logic       zero;

  // p_hi is product bits [7:3]; bits [2:0] always fall below the truncated fraction.
  function automatic logic [7:0] pack_product(
    input logic       s,
    input logic       z,
    input logic [3:0] xa,
    input logic [3:0] xb,
    input logic [4:0] p_hi
  );
    logic [2:0]        frac;
    logic signed [5:0] e;
    logic [7:0]        r;
    frac = p_hi[4] ? p_hi[3:1] : p_hi[2:0];
    e    = $signed({2'b00, xa}) + $signed({2'b00, xb}) - BIAS + $signed({5'b00000, p_hi[4]});
    if (z || (e <= 6'sd0)) begin
      r = 8'h00;
    end else if (e > 6'sd15) begin
`ifdef FLOAT_MUL_SATURATE_EN
      r = {s, 7'h7F};
`else
      r = {s, e[3:0], frac};
`endif
    end else begin
      r = {s, e[3:0], frac};
    end
    return r;
  endfunction

  // Operand capture: datapath registers, loaded only when a start is accepted.
  always_ff @(posedge clock) begin
    if ((state == IDLE) && bus.start) begin
      ma   <= {1'b1, bus.a[2:0]};
      mb   <= {1'b1, bus.b[2:0]};
      ea   <= bus.a[6:3];
      eb   <= bus.b[6:3];
      sign <= bus.a[7] ^ bus.b[7];
      zero <= (bus.a[6:0] == 7'h00) || (bus.b[6:0] == 7'h00);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      acc     <= 8'h00;
      cnt     <= 2'd0;
      y_r     <= 8'h00;
      valid_r <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            acc   <= 8'h00;
            cnt   <= 2'd0;
            state <= MUL;
          end
        end
        MUL: begin
          if (mb[cnt]) begin
            acc <= acc + ({4'b0000, ma} << cnt);
          end
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            state <= NORM;
          end
        end
        NORM: begin
          y_r     <= pack_product(sign, zero, ea, eb, acc[7:3]);
          valid_r <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy            = (state != IDLE);
  assign bus.y               = y_r;
  assign bus.is_output_valid = valid_r;

endmodule

// File: tb/tb_float_mul_e4m3.sv
// Directed-vector bench for float_mul_e4m3; expected products are hand-computed E4M3 values.
module tb_float_mul_e4m3;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clock = ~clock;

  float_mul_e4m3_if bus ();

  float_mul_e4m3 #(.EXP_BIAS(7)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Drives one multiply and waits (bounded) for its result; lat stays -1 on timeout.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, output logic [7:0] y,
                        output int lat, output logic busy_at_valid, output logic one_wide);
    @(negedge clock);
    bus.a = a;
    bus.b = b;
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    lat = -1;
    y = 8'hxx;
    busy_at_valid = 1'b1;
    one_wide = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      if (bus.is_output_valid) begin
        lat = k;
        y = bus.y;
        busy_at_valid = bus.busy;
        break;
      end
    end
    if (lat > 0) begin
      @(negedge clock);
      one_wide = !bus.is_output_valid;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.y !== 8'h00) begin errors++; $display("FAIL reset_y: got %h expected 00", bus.y); end
    checks++; if (bus.is_output_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.is_output_valid); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0] y; int lat; logic bz; logic w;
    run_op(8'h38, 8'h38, y, lat, bz, w);
    checks++; if (y !== 8'h38) begin errors++; $display("FAIL one_x_one: got %h expected 38", y); end
    checks++; if (lat !== 5) begin errors++; $display("FAIL latency: got %0d expected 5", lat); end
    checks++; if (bz !== 1'b0) begin errors++; $display("FAIL busy_at_valid: got %b expected 0", bz); end
    checks++; if (w !== 1'b1) begin errors++; $display("FAIL valid_width: got %b expected 1", w); end
    run_op(8'h3C, 8'h3C, y, lat, bz, w);
    checks++; if (y !== 8'h41) begin errors++; $display("FAIL 1p5_sq: got %h expected 41", y); end
    checks++; if (lat !== 5) begin errors++; $display("FAIL 1p5_sq_lat: got %0d expected 5", lat); end
  endtask

  task automatic test_sign_ignore();
    int pulses = 0; int at = -1; logic [7:0] y = 8'hxx;
    @(negedge clock);
    bus.a = 8'hC0; bus.b = 8'h3C; bus.start = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clock);
      if (k == 1) bus.start = 1'b0;
      if (k == 2) begin bus.a = 8'h38; bus.b = 8'h38; bus.start = 1'b1; end
      if (k == 3) bus.start = 1'b0;
      if (bus.is_output_valid) begin pulses++; at = k; y = bus.y; end
    end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL ignore_pulses: got %0d expected 1", pulses); end
    checks++; if (y !== 8'hC4) begin errors++; $display("FAIL neg_product: got %h expected c4", y); end
    checks++; if (at !== 6) begin errors++; $display("FAIL ignore_timing: got %0d expected 6", at); end
  endtask

  task automatic test_overflow();
    logic [7:0] y; int lat; logic bz; logic w;
    logic [7:0] exp_pos; logic [7:0] exp_neg;
`ifdef FLOAT_MUL_SATURATE_EN
    exp_pos = 8'h7F; exp_neg = 8'hFF;
`else
    exp_pos = 8'h46; exp_neg = 8'hC6;
`endif
    run_op(8'h7F, 8'h7F, y, lat, bz, w);
    checks++; if (y !== exp_pos) begin errors++; $display("FAIL overflow_pos: got %h expected %h", y, exp_pos); end
    run_op(8'hFF, 8'h7F, y, lat, bz, w);
    checks++; if (y !== exp_neg) begin errors++; $display("FAIL overflow_neg: got %h expected %h", y, exp_neg); end
  endtask

  task automatic test_underflow_zero();
    logic [7:0] y; int lat; logic bz; logic w;
    run_op(8'h3C, 8'h3C, y, lat, bz, w);
    run_op(8'h08, 8'h08, y, lat, bz, w);
    checks++; if (y !== 8'h00) begin errors++; $display("FAIL underflow: got %h expected 00", y); end
    run_op(8'h3C, 8'h3C, y, lat, bz, w);
    run_op(8'h80, 8'h3C, y, lat, bz, w);
    checks++; if (y !== 8'h00) begin errors++; $display("FAIL zero_a: got %h expected 00", y); end
    checks++; if (lat !== 5) begin errors++; $display("FAIL zero_latency: got %0d expected 5", lat); end
    run_op(8'hC0, 8'h80, y, lat, bz, w);
    checks++; if (y !== 8'h00) begin errors++; $display("FAIL zero_sign: got %h expected 00", y); end
  endtask

  task automatic test_abort();
    logic [7:0] y; int lat; logic bz; logic w; int pulses = 0;
    run_op(8'h3C, 8'h3C, y, lat, bz, w);
    @(negedge clock);
    bus.a = 8'h3C; bus.b = 8'h3C; bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.y !== 8'h00) begin errors++; $display("FAIL abort_y: got %h expected 00", bus.y); end
    checks++; if (bus.is_output_valid !== 1'b0) begin errors++; $display("FAIL abort_valid: got %b expected 0", bus.is_output_valid); end
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      if (bus.is_output_valid) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL abort_no_pulse: got %0d expected 0", pulses); end
    run_op(8'h38, 8'h38, y, lat, bz, w);
    checks++; if (y !== 8'h38) begin errors++; $display("FAIL abort_recover: got %h expected 38", y); end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    int idx [4];
    logic [7:0] ys [4];
    logic [7:0] exp_y [4];
    exp_y[0] = 8'h38; exp_y[1] = 8'h41; exp_y[2] = 8'h38; exp_y[3] = 8'h41;
    for (int i = 0; i < 4; i++) begin idx[i] = -1; ys[i] = 8'hxx; end
    @(negedge clock);
    bus.a = 8'h38; bus.b = 8'h38; bus.start = 1'b1;
    for (int k = 1; k <= 26; k++) begin
      @(negedge clock);
      if (bus.is_output_valid) begin
        if (pulses < 4) begin idx[pulses] = k; ys[pulses] = bus.y; end
        pulses++;
        bus.a = (bus.a == 8'h38) ? 8'h3C : 8'h38;
        bus.b = bus.a;
      end
    end
    bus.start = 1'b0;
    checks++; if (pulses !== 4) begin errors++; $display("FAIL b2b_pulses: got %0d expected 4", pulses); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (idx[i] !== 6 * (i + 1)) begin errors++; $display("FAIL b2b_slot%0d: got %0d expected %0d", i, idx[i], 6 * (i + 1)); end
      checks++; if (ys[i] !== exp_y[i]) begin errors++; $display("FAIL b2b_y%0d: got %h expected %h", i, ys[i], exp_y[i]); end
    end
    repeat (8) @(negedge clock);
  endtask

  initial begin
    bus.a = 8'h00;
    bus.b = 8'h00;
    bus.start = 1'b0;
    test_reset();
    test_basic();
    test_sign_ignore();
    test_overflow();
    test_underflow_zero();
    test_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/float_mul_e4m3.md
# float_mul_e4m3

Multi-cycle E4M3 8-bit floating-point multiplier; the product stage directly upstream of `float_adder_e4m3` in the multiply-accumulate path. It accepts one operand pair per `start` pulse and computes the 4x4 significand product with a 4-iteration shift-add loop. It normalises and packs the result, then presents `y` with a one-cycle `is_output_valid` pulse. The E4M3 encoding matches the adder: bit 7 sign, bits 6:3 exponent (bias 7), bits 2:0 fraction, implicit leading 1, no subnormals/NaN/Inf.

## Interface
- `EXP_BIAS`, default 7: exponent bias subtracted from the sum of operand exponents.

- `clock`  input  1  rising-edge clock
- `reset`  input  1  asynchronous, active-high reset
- `a`  input  8  operand A, sampled on the `start` edge only
- `b`  input  8  operand B, sampled on the `start` edge only
- `start`  input  1  begin a multiply; honoured only when `busy`=0
- `busy`  output  1  high from the edge after an accepted `start` until the result edge
- `y`  output  8  packed product; held until the next result
- `is_output_valid`  output  1  one-cycle pulse when `y` is updated

## Operation
- FSM states:
  - IDLE: `start`=1 → latch `a`, `b`; clear the 8-bit accumulator and 2-bit iteration counter; → MUL.
  - MUL: each cycle, if bit[cnt] of mb is set, add (ma << cnt) to the accumulator; cnt++. After cnt=3 → NORM.
  - NORM: pack, register `y`, assert `is_output_valid` → IDLE.
- ma = {1, a[2:0]} and mb = {1, b[2:0]}; the product p is 8 bits, range 64..225.
- A zero operand is exponent 0 and fraction 0 (8'h00 or 8'h80). If either operand is zero, `y` = 8'h00 (sign forced 0). Full latency still applies.
- Sign: a[7] ^ b[7].
- Normalise:
  - p[7]=1 → fraction = p[6:4], exponent += 1.
  - Otherwise → fraction = p[5:3].
  - Truncate, no rounding.
- Exponent is computed as signed 6-bit: e = a_e + b_e − EXP_BIAS + p[7].
  - e ≤ 0 → underflow: `y` = 8'h00.
  - e > 15 → overflow: see Configuration.
  - Otherwise `y` = {sign, e[3:0], fraction}.
- `start` while `busy`=1 is ignored; the in-flight operation is not disturbed and operands are not re-sampled.
- `start` in the same cycle that `is_output_valid` is high is accepted (FSM is in IDLE).
- Reset values: `y`=8'h00, `is_output_valid`=0, `busy`=0, state IDLE, accumulator and counter 0.
- Reset mid-operation aborts immediately. No `is_output_valid` pulse is produced for the aborted operation.

## Timing
- Edge E0 samples `start`=1 in IDLE.
- MUL iterations occur on edges E1..E4.
- NORM registers `y` and sets `is_output_valid` on E5.
- `is_output_valid` is high for the cycle after E5 and clears on E6.
- `busy` is high after E0 through the E5 edge; low in the cycle `is_output_valid` is high.
- Latency: 5 cycles from `start` to valid `y`. Throughput: one result per 6 cycles with back-to-back `start`.
- `y` is stable between result edges; it can feed `float_adder_e4m3` operand inputs directly.

## Configuration
- `FLOAT_MUL_SATURATE_EN` defined: on overflow (e > 15), `y` = {sign, 7'h7F}, the maximum magnitude.
- `FLOAT_MUL_SATURATE_EN` undefined: the exponent wraps. `y` = {sign, e[3:0], fraction}, matching the adder's unchecked exponent arithmetic.
- Underflow handling is identical in both builds.

## Test plan
- Reset asserted mid-MUL with a=8'h3C, b=8'h3C → `busy`=0, `y`=8'h00, `is_output_valid`=0 immediately. After release, no pulse.
- a=8'h38, b=8'h38 (1.0 × 1.0) → `y`=8'h38, valid pulse exactly 5 cycles after `start`. Then a=8'h3C, b=8'h3C (1.5 × 1.5) → `y`=8'h41 (2.25).
- a=8'hC0, b=8'h3C (−2.0 × 1.5) → `y`=8'hC4 (−3.0). Second `start` pulsed at E2 with a=8'h38 → ignored; single result 8'hC4.
- a=8'h7F, b=8'h7F:
  - with `FLOAT_MUL_SATURATE_EN` → `y`=8'h7F;
  - without → `y`=8'h46.
- a=8'h08, b=8'h08 → `y`=8'h00 (underflow). a=8'h80, b=8'h3C → `y`=8'h00 (zero operand, full 5-cycle latency).
- `start` held high continuously with alternating operands 8'h38/8'h3C → results every 6 cycles, each `is_output_valid` exactly one cycle wide.
